// File: rtl/interlock_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : core_pkg                                                   |
// | Purpose : Shared types and constants for the integer pipeline        |
// |           hazard control (register numbers, bypass selects).         |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package core_pkg;

   localparam int NREGS = 32;

   typedef logic [4:0] reg_addr_t;

   typedef enum logic [1:0] {
      SEL_RF  = 2'd0,
      SEL_MEM = 2'd1,
      SEL_WB  = 2'd2
   } bypass_sel_e;

   // x0 is hardwired zero, so it never takes part in any hazard.
   function automatic logic is_real_reg(reg_addr_t a);
      return a != '0;
   endfunction

   // Youngest producer wins: the EX-stage instruction is younger than MEM.
   function automatic bypass_sel_e fwd_sel(logic ren, reg_addr_t rs,
                                           logic ex_wr, reg_addr_t ex_a,
                                           logic mem_wr, reg_addr_t mem_a);
      bypass_sel_e sel;
      sel = SEL_RF;
      if (ren && is_real_reg(rs)) begin
         if (ex_wr && ex_a == rs)
            sel = SEL_MEM;
         else if (mem_wr && mem_a == rs)
            sel = SEL_WB;
      end
      return sel;
   endfunction

endpackage
`default_nettype wire

// File: rtl/interlock_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface: interlock_ctrl_if                                         |
// | Purpose  : Pipeline-stage status into the hazard controller and its  |
// |            stall / bypass / write-port decisions back out.           |
// |            master = pipeline side, slave = interlock_ctrl.           |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface interlock_ctrl_if;
   import core_pkg::*;

   logic      id_valid, id_ren1, id_ren2, id_wxd, id_long;
   reg_addr_t id_rs1, id_rs2, id_waddr;
   logic      ex_valid, ex_wxd, ex_load, ex_stall;
   reg_addr_t ex_waddr;
   logic      mem_valid, mem_wxd, mem_wait;
   reg_addr_t mem_waddr;
   logic      wb_valid, wb_wxd;
   reg_addr_t wb_waddr;
   logic      ll_wb_valid;
   reg_addr_t ll_wb_waddr;
   logic      ll_wb_ready;
   logic      id_stall;
   logic [1:0] ex_sel1, ex_sel2;
   logic      rf_wen, rf_wsrc;

   modport master (
      output id_valid, id_ren1, id_ren2, id_wxd, id_long, id_rs1, id_rs2, id_waddr,
      output ex_valid, ex_wxd, ex_load, ex_stall, ex_waddr,
      output mem_valid, mem_wxd, mem_wait, mem_waddr,
      output wb_valid, wb_wxd, wb_waddr, ll_wb_valid, ll_wb_waddr,
      input  ll_wb_ready, id_stall, ex_sel1, ex_sel2, rf_wen, rf_wsrc
   );

   modport slave (
      input  id_valid, id_ren1, id_ren2, id_wxd, id_long, id_rs1, id_rs2, id_waddr,
      input  ex_valid, ex_wxd, ex_load, ex_stall, ex_waddr,
      input  mem_valid, mem_wxd, mem_wait, mem_waddr,
      input  wb_valid, wb_wxd, wb_waddr, ll_wb_valid, ll_wb_waddr,
      output ll_wb_ready, id_stall, ex_sel1, ex_sel2, rf_wen, rf_wsrc
   );

endinterface
`default_nettype wire

// File: rtl/interlock_ctrl_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : scoreboard                                                 |
// | Purpose : One pending bit per register for in-flight long-latency    |
// |           writes. Ports: set (dispatch), clear (writeback grant),    |
// |           two source read ports and one WAW check port.              |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module scoreboard
   import core_pkg::*;
(
   input  wire logic      clk,
   input  wire logic      rst,
   input  wire logic      i_set_en,
   input  wire reg_addr_t i_set_addr,
   input  wire logic      i_clr_en,
   input  wire reg_addr_t i_clr_addr,
   input  wire reg_addr_t i_rd1_addr,
   input  wire reg_addr_t i_rd2_addr,
   input  wire reg_addr_t i_waw_addr,
   output logic           o_rd1,
   output logic           o_rd2,
   output logic           o_waw
);

   logic [NREGS-1:0] r_sb;

   // Set after clear so a same-index collision would favour "pending";
   // the pipeline guarantees that collision cannot happen.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sb <= '0;
      end else begin
         if (i_clr_en)
            r_sb[i_clr_addr] <= 1'b0;
         if (i_set_en && is_real_reg(i_set_addr))
            r_sb[i_set_addr] <= 1'b1;
      end
   end

   // Reads see the current value, so a bit being cleared this cycle still reports pending.
   assign o_rd1 = r_sb[i_rd1_addr] & is_real_reg(i_rd1_addr);
   assign o_rd2 = r_sb[i_rd2_addr] & is_real_reg(i_rd2_addr);
   assign o_waw = r_sb[i_waw_addr] & is_real_reg(i_waw_addr);

endmodule
`default_nettype wire

// File: rtl/interlock_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : interlock_ctrl                                             |
// | Purpose : Issue-stage hazard controller. Decides ID stall (load-use, |
// |           long-latency scoreboard, dcache wait, writeback starve),   |
// |           registers EX bypass selects, and arbitrates the single     |
// |           register-file write port between WB and the mul/div unit.  |
// | Ports   : clk, rst (async active-high), bus (interlock_ctrl_if.slave)|
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module interlock_ctrl
   import core_pkg::*;
#(
   parameter int STARVE = 4
)(
   input  wire logic     clk,
   input  wire logic     rst,
   interlock_ctrl_if.slave bus
);

   localparam int CW = $clog2(STARVE + 1);
   localparam logic [CW-1:0] c_starve_max = CW'(STARVE);

   logic        w_wb_wr, w_ex_wr, w_mem_wr;
   logic        w_ll_ready;
   logic        w_load_use;
   logic        w_sb_rd1, w_sb_rd2, w_sb_waw;
   logic        w_sb_raw, w_sb_waw_hit;
   logic        w_starve;
   logic        w_id_stall;
   logic        w_id_fire;
   bypass_sel_e w_nsel1, w_nsel2;
   bypass_sel_e r_sel1, r_sel2;
   logic [CW-1:0] r_starve_cnt;

   assign w_wb_wr  = bus.wb_valid & bus.wb_wxd;
   assign w_ex_wr  = bus.ex_valid & bus.ex_wxd & is_real_reg(bus.ex_waddr);
   assign w_mem_wr = bus.mem_valid & bus.mem_wxd & is_real_reg(bus.mem_waddr);

   // Write port: WB always wins; long-latency result waits.
   assign w_ll_ready = bus.ll_wb_valid & ~w_wb_wr;

   assign w_load_use = w_ex_wr & bus.ex_load &
                       ((bus.id_ren1 & is_real_reg(bus.id_rs1) & (bus.id_rs1 == bus.ex_waddr)) |
                        (bus.id_ren2 & is_real_reg(bus.id_rs2) & (bus.id_rs2 == bus.ex_waddr)));

   assign w_sb_raw     = (bus.id_ren1 & w_sb_rd1) | (bus.id_ren2 & w_sb_rd2);
   assign w_sb_waw_hit = bus.id_wxd & w_sb_waw;

   assign w_starve   = (r_starve_cnt == c_starve_max);
   assign w_id_stall = bus.mem_wait |
                       (bus.id_valid & (w_load_use | w_sb_raw | w_sb_waw_hit)) |
                       w_starve;
   assign w_id_fire  = bus.id_valid & ~w_id_stall & ~bus.ex_stall;

   scoreboard u_sb (
      .clk        (clk),
      .rst        (rst),
      .i_set_en   (w_id_fire & bus.id_long & bus.id_wxd),
      .i_set_addr (bus.id_waddr),
      .i_clr_en   (w_ll_ready),
      .i_clr_addr (bus.ll_wb_waddr),
      .i_rd1_addr (bus.id_rs1),
      .i_rd2_addr (bus.id_rs2),
      .i_waw_addr (bus.id_waddr),
      .o_rd1      (w_sb_rd1),
      .o_rd2      (w_sb_rd2),
      .o_waw      (w_sb_waw)
   );

   // A WB-stage producer needs no bypass: the regfile writes through.
   assign w_nsel1 = fwd_sel(bus.id_ren1, bus.id_rs1, w_ex_wr, bus.ex_waddr, w_mem_wr, bus.mem_waddr);
   assign w_nsel2 = fwd_sel(bus.id_ren2, bus.id_rs2, w_ex_wr, bus.ex_waddr, w_mem_wr, bus.mem_waddr);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sel1 <= SEL_RF;
         r_sel2 <= SEL_RF;
      end else if (!bus.ex_stall) begin
         if (w_id_stall || !bus.id_valid) begin
            r_sel1 <= SEL_RF;
            r_sel2 <= SEL_RF;
         end else begin
            r_sel1 <= w_nsel1;
            r_sel2 <= w_nsel2;
         end
      end
   end

   // Once saturated, the forced ID stall lets bubbles drain into WB so the
   // long-latency result eventually gets the write port.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_starve_cnt <= '0;
      else if (!bus.ll_wb_valid || w_ll_ready)
         r_starve_cnt <= '0;
      else if (!w_starve)
         r_starve_cnt <= r_starve_cnt + 1'b1;
   end

   assign bus.ll_wb_ready = w_ll_ready;
   assign bus.id_stall    = w_id_stall;
   assign bus.ex_sel1     = r_sel1;
   assign bus.ex_sel2     = r_sel2;
   assign bus.rf_wen      = w_wb_wr | w_ll_ready;
   assign bus.rf_wsrc     = w_ll_ready;

endmodule
`default_nettype wire

// File: tb/tb_interlock_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_interlock_ctrl                                          |
// | Purpose : Directed stimulus with a queue of expected responses; a    |
// |           negedge monitor pops and compares (-1 = don't care).       |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_interlock_ctrl;
   import core_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   nchk = 0;
   int   npass = 0;

   interlock_ctrl_if bus ();

   interlock_ctrl #(.STARVE(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int    cyc;
      string nm;
      int    stall;
      int    llr;
      int    wen;
      int    wsrc;
      int    s1;
      int    s2;
   } exp_t;

   exp_t q[$];
   exp_t e;

   function automatic void push(int c, string nm, int st, int lr, int we, int ws, int a, int b);
      exp_t x;
      x.cyc = c; x.nm = nm; x.stall = st; x.llr = lr; x.wen = we; x.wsrc = ws; x.s1 = a; x.s2 = b;
      q.push_back(x);
   endfunction

   task automatic chk(string nm, string field, int act, int exp);
      if (exp >= 0) begin
         nchk++;
         if (act == exp) npass++;
         else $display("FAIL %s.%s: got %0d expected %0d (cycle %0d)", nm, field, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         e = q.pop_front();
         chk(e.nm, "id_stall",    int'(bus.id_stall),    e.stall);
         chk(e.nm, "ll_wb_ready", int'(bus.ll_wb_ready), e.llr);
         chk(e.nm, "rf_wen",      int'(bus.rf_wen),      e.wen);
         chk(e.nm, "rf_wsrc",     int'(bus.rf_wsrc),     e.wsrc);
         chk(e.nm, "ex_sel1",     int'(bus.ex_sel1),     e.s1);
         chk(e.nm, "ex_sel2",     int'(bus.ex_sel2),     e.s2);
      end
   end

   task automatic idle();
      bus.id_valid = 0; bus.id_ren1 = 0; bus.id_ren2 = 0; bus.id_wxd = 0; bus.id_long = 0;
      bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_waddr = 0;
      bus.ex_valid = 0; bus.ex_wxd = 0; bus.ex_load = 0; bus.ex_stall = 0; bus.ex_waddr = 0;
      bus.mem_valid = 0; bus.mem_wxd = 0; bus.mem_wait = 0; bus.mem_waddr = 0;
      bus.wb_valid = 0; bus.wb_wxd = 0; bus.wb_waddr = 0;
      bus.ll_wb_valid = 0; bus.ll_wb_waddr = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic id_read1(reg_addr_t r);
      bus.id_valid = 1; bus.id_ren1 = 1; bus.id_rs1 = r;
   endtask

   initial begin
      idle();
      step();
      step();
      rst = 0;
      push(cyc, "reset", 0, 0, 0, 0, 0, 0);

      // Load-use on x5: one bubble, then bypass from WB stage.
      step();
      id_read1(5'd5);
      bus.ex_valid = 1; bus.ex_wxd = 1; bus.ex_load = 1; bus.ex_waddr = 5'd5;
      push(cyc, "lu_stall", 1, 0, 0, 0, -1, -1);
      push(cyc + 1, "lu_bubble", -1, -1, -1, -1, 0, 0);
      step();
      id_read1(5'd5);
      bus.mem_valid = 1; bus.mem_wxd = 1; bus.mem_waddr = 5'd5;
      push(cyc, "lu_go", 0, 0, 0, 0, -1, -1);
      push(cyc + 1, "lu_sel", -1, -1, -1, -1, 2, 0);

      // ALU x7 in EX and MEM; youngest (EX) wins on rs2.
      step();
      bus.id_valid = 1; bus.id_ren2 = 1; bus.id_rs2 = 5'd7;
      bus.ex_valid = 1; bus.ex_wxd = 1; bus.ex_waddr = 5'd7;
      bus.mem_valid = 1; bus.mem_wxd = 1; bus.mem_waddr = 5'd7;
      push(cyc, "alu_nostall", 0, 0, 0, 0, -1, -1);
      push(cyc + 1, "alu_sel", -1, -1, -1, -1, 0, 1);

      // Div to x9, dependent read waits for the grant.
      step();
      bus.id_valid = 1; bus.id_long = 1; bus.id_wxd = 1; bus.id_waddr = 5'd9;
      push(cyc, "div_issue", 0, 0, 0, 0, -1, -1);
      for (int i = 0; i < 2; i++) begin
         step();
         id_read1(5'd9);
         push(cyc, "div_raw", 1, 0, 0, 0, 0, 0);
      end
      step();
      id_read1(5'd9);
      bus.ll_wb_valid = 1; bus.ll_wb_waddr = 5'd9;
      push(cyc, "div_grant", 1, 1, 1, 1, -1, -1);
      step();
      id_read1(5'd9);
      push(cyc, "div_release", 0, 0, 0, 0, -1, -1);
      push(cyc + 1, "div_sel", -1, -1, -1, -1, 0, 0);

      // Starvation: WB busy 5 cycles, forced stall from the 5th.
      for (int i = 1; i <= 6; i++) begin
         step();
         id_read1(5'd1);
         bus.ll_wb_valid = 1; bus.ll_wb_waddr = 5'd12;
         if (i <= 5) begin
            bus.wb_valid = 1; bus.wb_wxd = 1; bus.wb_waddr = 5'd2;
         end
         if (i <= 4)      push(cyc, "starve_deny", 0, 0, 1, 0, -1, -1);
         else if (i == 5) push(cyc, "starve_force", 1, 0, 1, 0, -1, -1);
         else             push(cyc, "starve_grant", 1, 1, 1, 1, -1, -1);
      end
      step();
      id_read1(5'd1);
      push(cyc, "starve_clear", 0, 0, 0, 0, -1, -1);

      // x0 everywhere: no stall, no bypass, no scoreboard entry.
      step();
      bus.id_valid = 1; bus.id_ren1 = 1; bus.id_ren2 = 1; bus.id_wxd = 1; bus.id_long = 1;
      bus.ex_valid = 1; bus.ex_wxd = 1; bus.ex_load = 1;
      bus.mem_valid = 1; bus.mem_wxd = 1;
      push(cyc, "x0_nostall", 0, 0, 0, 0, -1, -1);
      push(cyc + 1, "x0_sel", -1, -1, -1, -1, 0, 0);
      step();
      bus.id_valid = 1; bus.id_ren1 = 1; bus.id_wxd = 1;
      push(cyc, "x0_waw", 0, 0, 0, 0, -1, -1);

      // dcache wait stalls regardless of ID.
      step();
      bus.mem_wait = 1;
      push(cyc, "mem_wait", 1, 0, 0, 0, -1, -1);

      // Async reset with sb[3] pending and ex_sel1 = 1 held by ex_stall.
      step();
      bus.id_valid = 1; bus.id_long = 1; bus.id_wxd = 1; bus.id_waddr = 5'd3;
      push(cyc, "sb3_issue", 0, 0, 0, 0, -1, -1);
      step();
      id_read1(5'd4);
      bus.ex_valid = 1; bus.ex_wxd = 1; bus.ex_waddr = 5'd4;
      push(cyc + 1, "hold_sel", 1, -1, -1, -1, 1, 0);
      step();
      bus.ex_stall = 1;
      id_read1(5'd3);
      step();
      bus.ex_stall = 1;
      push(cyc, "async_rst", 0, 0, 0, 0, 0, 0);
      #1 rst = 1;
      step();
      rst = 0;
      id_read1(5'd3);
      push(cyc, "sb_cleared", 0, 0, 0, 0, 0, 0);

      step();
      step();
      if (q.size() != 0) begin
         nchk++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
`default_nettype wire
